// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: accepts a WIDTH-bit word on valid/ready and shifts it out MSB first.
// Latency: first bit one cycle after accept; ready in the last-bit cycle permits gap-free back-to-back words.
module piso_serializer #(
   parameter int   WIDTH    = 4,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             serial_out,
   output logic             bit_valid,
   output logic             word_done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic             accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      bit_valid  = (state_q == SHIFT);
      word_done  = (state_q == SHIFT) && (cnt_q == LAST);
      serial_out = (state_q == SHIFT) ? shreg_q[WIDTH-1] : IDLE_BIT;
      data_ready = !reset && ((state_q == IDLE) || word_done);
      accept     = data_valid && data_ready;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               shreg_d = data_in;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (cnt_q != LAST) begin
               shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
               cnt_d   = cnt_q + 1'b1;
            end else if (accept) begin
               // Reload in the last-bit cycle so the next word follows with no idle gap.
               shreg_d = data_in;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboarded bench for piso_serializer, with a 4-bit SIPO downstream shifted on bit_valid cycles.
module tb_piso_serializer;

   localparam int   W  = 4;
   localparam logic IB = 1'b0;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         data_valid = 1'b0;
   logic [W-1:0] data_in = '0;
   logic         data_ready, serial_out, bit_valid, word_done;

   piso_serializer #(.WIDTH(W), .IDLE_BIT(IB)) dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .serial_out (serial_out),
      .bit_valid  (bit_valid),
      .word_done  (word_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         b;
      logic         last;
      logic [W-1:0] word;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [3:0]   sipo_q;
   logic         sipo_pend = 1'b0;
   logic [W-1:0] sipo_word = '0;

   always @(posedge clk)
      if (bit_valid === 1'b1) sipo_q <= {sipo_q[2:0], serial_out};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, check this cycle's outputs, and book any accepted word.
   task automatic tick(input logic r, input logic v, input logic [W-1:0] d);
      exp_t e;
      logic rdy;
      reset      = r;
      data_valid = v;
      data_in    = d;
      @(negedge clk);
      rdy = !r && (exp_q.size() <= 1);
      check("data_ready", 32'(data_ready), 32'(rdy));
      check("bit_valid", 32'(bit_valid), 32'(exp_q.size() > 0));
      if (sipo_pend) begin
         check("sipo_out", 32'(sipo_q), 32'(sipo_word));
         sipo_pend = 1'b0;
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("serial_out", 32'(serial_out), 32'(e.b));
         check("word_done", 32'(word_done), 32'(e.last));
         if (e.last) begin
            sipo_pend = 1'b1;
            sipo_word = e.word;
         end
      end else begin
         check("serial_out_idle", 32'(serial_out), 32'(IB));
         check("word_done_idle", 32'(word_done), 32'd0);
      end
      if (r) exp_q.delete();
      else if (v && rdy)
         for (int i = W - 1; i >= 0; i--)
            exp_q.push_back('{b: d[i], last: (i == 0), word: d});
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      data_valid = 1'b1;
      @(posedge clk);
      #1;
      // Reset held with a pending producer: nothing may be accepted.
      repeat (3) tick(1'b1, 1'b1, 4'hF);
      tick(1'b0, 1'b0, 4'h0);

      // Single word.
      tick(1'b0, 1'b1, 4'b1011);
      repeat (5) tick(1'b0, 1'b0, 4'b1011);

      // Back-to-back words with data_valid held.
      tick(1'b0, 1'b1, 4'hA);
      repeat (4) tick(1'b0, 1'b1, 4'h5);
      repeat (5) tick(1'b0, 1'b0, 4'h0);

      // Input changes while busy are ignored.
      tick(1'b0, 1'b1, 4'hC);
      repeat (4) tick(1'b0, 1'b1, 4'h3);
      repeat (5) tick(1'b0, 1'b0, 4'h0);

      // Reset mid-word discards the partial word.
      tick(1'b0, 1'b1, 4'hF);
      tick(1'b0, 1'b0, 4'h0);
      tick(1'b1, 1'b0, 4'h0);
      tick(1'b0, 1'b0, 4'h0);
      tick(1'b0, 1'b1, 4'h6);
      repeat (5) tick(1'b0, 1'b0, 4'h0);

      // Two words through the SIPO.
      tick(1'b0, 1'b1, 4'h9);
      repeat (3) tick(1'b0, 1'b0, 4'h0);
      tick(1'b0, 1'b1, 4'hE);
      repeat (5) tick(1'b0, 1'b0, 4'h0);

      // Random traffic with occasional resets.
      repeat (300)
         tick(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), W'($urandom));
      repeat (6) tick(1'b0, 1'b0, 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
